compare_n_serial: RTL and testbench

- Parametrised, multi-cycle successor to the 2-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands A and B, MSB-first, STEP bits per clock.
- Stops early at the first differing digit.
- start/busy/done handshake with registered A_lt_B / A_gt_B / A_eq_B results; used wherever a small serial comparator replaces a wide combinational one.

---
 rtl/compare_n_serial_if.sv | 29 ++
 rtl/compare_n_serial.sv | 87 ++++++++
 tb/tb_compare_n_serial.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/compare_n_serial_if.sv
// Request/result bundle for the serial magnitude comparator.
// WIDTH/STEP must match the compare_n_serial instance the interface is bound to.
interface compare_n_serial_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
);
  localparam int K  = WIDTH / STEP;
  localparam int CW = $clog2(K) + 1;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_lt_B;
  logic             A_gt_B;
  logic             A_eq_B;
  logic [CW-1:0]    digits_used;

  modport master (
    output start, A, B,
    input  busy, done, A_lt_B, A_gt_B, A_eq_B, digits_used
  );

  modport slave (
    input  start, A, B,
    output busy, done, A_lt_B, A_gt_B, A_eq_B, digits_used
  );
endinterface

// File: rtl/compare_n_serial.sv
// Serial MSB-first magnitude comparator, STEP bits per clock, early exit on first differing digit.
// Optional build macro COMPARE_SIGNED_EN: treat operands as two's-complement.
module compare_n_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  compare_n_serial_if.slave  cmp
);
  localparam int K  = WIDTH / STEP;
  localparam int CW = $clog2(K) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] a_in, b_in;
  logic [CW-1:0]    cnt;
  logic [STEP-1:0]  da, db;

`ifdef COMPARE_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_in = cmp.A ^ MSB;
  assign b_in = cmp.B ^ MSB;
`else
  assign a_in = cmp.A;
  assign b_in = cmp.B;
`endif

  // The digit under test always sits at the top of the shift registers.
  assign da = a_sh[WIDTH-1 -: STEP];
  assign db = b_sh[WIDTH-1 -: STEP];

  assign cmp.busy = (state == S_RUN);
  assign cmp.done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      a_sh            <= '0;
      b_sh            <= '0;
      cnt             <= '0;
      cmp.A_lt_B      <= 1'b0;
      cmp.A_gt_B      <= 1'b0;
      cmp.A_eq_B      <= 1'b0;
      cmp.digits_used <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (da != db) begin
            cmp.A_lt_B      <= (da < db);
            cmp.A_gt_B      <= (da > db);
            cmp.digits_used <= cnt + 1'b1;
            state           <= S_DONE;
          end else if (cnt == CW'(K - 1)) begin
            cmp.A_eq_B      <= 1'b1;
            cmp.digits_used <= CW'(K);
            state           <= S_DONE;
          end else begin
            cnt  <= cnt + 1'b1;
            a_sh <= a_sh << STEP;
            b_sh <= b_sh << STEP;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
          if (cmp.start) begin
            a_sh            <= a_in;
            b_sh            <= b_in;
            cnt             <= '0;
            cmp.A_lt_B      <= 1'b0;
            cmp.A_gt_B      <= 1'b0;
            cmp.A_eq_B      <= 1'b0;
            cmp.digits_used <= '0;
            state           <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_compare_n_serial.sv
// Directed + exhaustive bench for compare_n_serial (8/2 and 4/1 configurations).
module tb_compare_n_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_n_serial_if #(.WIDTH(8), .STEP(2)) if8 ();
  compare_n_serial_if #(.WIDTH(4), .STEP(1)) if4 ();

  compare_n_serial #(.WIDTH(8), .STEP(2)) dut8 (.clk(clk), .rst(rst), .cmp(if8));
  compare_n_serial #(.WIDTH(4), .STEP(1)) dut4 (.clk(clk), .rst(rst), .cmp(if4));

  int n_tot  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

`ifdef COMPARE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Index of first differing digit (K-1 when equal); latency and digits_used both follow from it.
  function automatic int first_diff(input int a, input int b, input int w, input int s);
    for (int i = 0; i < w / s; i++) begin
      int sh = w - s * (i + 1);
      if (((a >> sh) & ((1 << s) - 1)) != ((b >> sh) & ((1 << s) - 1))) return i;
    end
    return w / s - 1;
  endfunction

  function automatic int cmp_val(input int a, input int b, input int w);
    int x = a, y = b;
    if (SGN) begin
      if (x >= (1 << (w - 1))) x -= (1 << w);
      if (y >= (1 << (w - 1))) y -= (1 << w);
    end
    return (x < y) ? -1 : (x > y) ? 1 : 0;
  endfunction

  // Cycle model of the 8-bit unit: a countdown of remaining busy clocks.
  int   m_left = 0;
  int   p_c = 0, p_du = 0;
  logic m_done = 0, m_lt = 0, m_gt = 0, m_eq = 0;
  logic [7:0] m_du = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_done <= 0; m_lt <= 0; m_gt <= 0; m_eq <= 0; m_du <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1; m_lt <= (p_c < 0); m_gt <= (p_c > 0); m_eq <= (p_c == 0);
        m_du <= 8'(p_du);
      end
    end else begin
      m_done <= 0;
      if (if8.start) begin
        m_left <= first_diff(int'(if8.A), int'(if8.B), 8, 2) + 1;
        p_du   <= first_diff(int'(if8.A), int'(if8.B), 8, 2) + 1;
        p_c    <= cmp_val(int'(if8.A), int'(if8.B), 8);
        m_lt <= 0; m_gt <= 0; m_eq <= 0; m_du <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en)
      chk("cycle8", {19'd0, if8.busy, if8.done, if8.A_lt_B, if8.A_gt_B, if8.A_eq_B, 5'(if8.digits_used)},
                    {19'd0, (m_left > 0), m_done, m_lt, m_gt, m_eq, m_du[4:0]});
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, output int nb);
    @(negedge clk); if8.start = 1; if8.A = a; if8.B = b;
    @(negedge clk); if8.start = 0;
    nb = 0;
    for (int i = 0; i < 20 && !if8.done; i++) begin
      if (if8.busy) nb++;
      @(negedge clk);
    end
    if (!if8.done) chk("done8_timeout", 0, 1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int nb = 0, d, c;
    @(negedge clk); if4.start = 1; if4.A = a; if4.B = b;
    @(negedge clk); if4.start = 0;
    for (int i = 0; i < 20 && !if4.done; i++) begin
      if (if4.busy) begin
        nb++;
        if ({if4.A_lt_B, if4.A_gt_B, if4.A_eq_B} != 3'b000) chk("flags_while_busy4", 1, 0);
      end
      @(negedge clk);
    end
    if (!if4.done) chk("done4_timeout", 0, 1);
    d = first_diff(int'(a), int'(b), 4, 1);
    c = cmp_val(int'(a), int'(b), 4);
    chk($sformatf("sweep4 a=%h b=%h", a, b),
        {13'd0, if4.A_lt_B, if4.A_gt_B, if4.A_eq_B, 8'(if4.digits_used), 8'(nb)},
        {13'd0, (c < 0), (c > 0), (c == 0), 8'(d + 1), 8'(d + 1)});
    chk("onehot4", 32'($countones({if4.A_lt_B, if4.A_gt_B, if4.A_eq_B})), 1);
  endtask

  initial begin
    int nb, ndone;
    if8.start = 0; if8.A = 0; if8.B = 0;
    if4.start = 0; if4.A = 0; if4.B = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset8", {if8.busy, if8.done, if8.A_lt_B, if8.A_gt_B, if8.A_eq_B, 3'(if8.digits_used)}, 0);
    chk("reset4", {if4.busy, if4.done, if4.A_lt_B, if4.A_gt_B, if4.A_eq_B, 3'(if4.digits_used)}, 0);
    mon_en = 1;

    // Equal operands: four busy clocks, then eq with all four digits used.
    go8(8'h5A, 8'h5A, nb);
    chk("eq_busy", nb, 4);
    chk("eq_flags", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B}, 3'b001);
    chk("eq_du", 32'(if8.digits_used), 4);

    go8(8'hC0, 8'h3F, nb);
    chk("msd_busy", nb, 1);
    chk("msd_flags", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B}, SGN ? 3'b100 : 3'b010);
    chk("msd_du", 32'(if8.digits_used), 1);

    go8(8'h12, 8'h13, nb);
    chk("lsd_busy", nb, 4);
    chk("lsd_flags", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B}, 3'b100);
    chk("lsd_du", 32'(if8.digits_used), 4);

    go8(8'h80, 8'h7F, nb);
    chk("sign_flags8", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B}, SGN ? 3'b100 : 3'b010);

    // start held through RUN with new operands, then back-to-back from DONE.
    @(negedge clk); if8.start = 1; if8.A = 8'h12; if8.B = 8'h13;
    @(negedge clk); if8.A = 8'hFF; if8.B = 8'h00;
    for (int i = 0; i < 20 && !if8.done; i++) @(negedge clk);
    chk("hold_flags", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B, 5'(if8.digits_used)}, {3'b100, 5'd4});
    @(negedge clk); if8.start = 0;
    chk("b2b_no_idle", {if8.busy, if8.done}, 2'b10);
    for (int i = 0; i < 20 && !if8.done; i++) @(negedge clk);
    chk("b2b_flags", {if8.A_lt_B, if8.A_gt_B, if8.A_eq_B, 5'(if8.digits_used)},
        {SGN ? 3'b100 : 3'b010, 5'd1});

    // Reset on the second RUN edge aborts silently.
    @(negedge clk); if8.start = 1; if8.A = 8'h12; if8.B = 8'h13;
    @(negedge clk); if8.start = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_state", {if8.busy, if8.done, if8.A_lt_B, if8.A_gt_B, if8.A_eq_B, 3'(if8.digits_used)}, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (if8.done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b));

    run4(4'h8, 4'h7);
    chk("sign_flags4", {if4.A_lt_B, if4.A_gt_B, if4.A_eq_B}, SGN ? 3'b100 : 3'b010);

    mon_en = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
